// File: rtl/glitch_wb_master_pkg.sv
// Shared definitions for the glitch engine Wishbone initiator: register map
// of the glitch configuration slave and the initiator's FSM states.
package glitch_wb_master_pkg;

   // Glitch configuration slave register map (4-bit byte addresses).
   localparam logic [3:0] GLITCH_STATUS  = 4'h0;
   localparam logic [3:0] GLITCH_QUEUE_0 = 4'h4;
   localparam logic [3:0] GLITCH_QUEUE_1 = 4'h5;
   localparam logic [3:0] GLITCH_QUEUE_2 = 4'h6;
   localparam logic [3:0] GLITCH_QUEUE_3 = 4'h7;

   typedef enum logic [2:0] {
      GLITCH_WBM_IDLE,
      GLITCH_WBM_STB,
      GLITCH_WBM_WAIT,
      GLITCH_WBM_PSTB,
      GLITCH_WBM_PWAIT
   } wbm_state_e;

   // Queue register address for entry byte idx.
   function automatic logic [3:0] queue_adr(input logic [1:0] idx);
      case (idx)
         2'd0:    return GLITCH_QUEUE_0;
         2'd1:    return GLITCH_QUEUE_1;
         2'd2:    return GLITCH_QUEUE_2;
         default: return GLITCH_QUEUE_3;
      endcase
   endfunction

endpackage

// File: rtl/glitch_wb_master_if.sv
// 8-bit Wishbone link between the glitch initiator and the glitch
// configuration slave. Signal names are from the initiator's point of view.
interface glitch_wb_master_if;

   logic [3:0] wb_adr_o;
   logic [7:0] wb_dat_o;
   logic       wb_we_o;
   logic       wb_stb_o;
   logic [7:0] wb_dat_i;
   logic       wb_ack_i;

   modport master (
      output wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o,
      input  wb_dat_i, wb_ack_i
   );

   modport slave (
      input  wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o,
      output wb_dat_i, wb_ack_i
   );

endinterface

// File: rtl/glitch_wb_master.sv
// Wishbone initiator for the glitch engine configuration slave. Serialises
// 32-bit glitch entries into four byte writes to GLITCH_QUEUE_0..3, retries
// the QUEUE_3 write while the slave FIFO is full, and periodically polls
// GLITCH_STATUS to mirror the engine ready bit.
module glitch_wb_master
   import glitch_wb_master_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 4,
   parameter int unsigned MAX_RETRIES = 255,
   parameter int unsigned POLL_PERIOD = 1024
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      cmd_valid_i,
   input  logic [31:0]               cmd_data_i,
   output logic                      cmd_ready_o,
   output logic                      done_o,
   output logic                      err_o,
   output logic                      busy_o,
   output logic                      status_ready_o,
   glitch_wb_master_if.master        wb
);

   localparam bit              POLL_EN     = (POLL_PERIOD != 0);
   localparam int unsigned     IDLE_W      = POLL_EN ? $clog2(POLL_PERIOD + 1) : 1;
   localparam logic [IDLE_W-1:0] POLL_LAST = POLL_EN ? IDLE_W'(POLL_PERIOD - 1) : '0;
   localparam logic [3:0]      TMO_LAST    = 4'(ACK_TIMEOUT - 1);
   localparam logic [8:0]      RETRY_LIMIT = 9'(MAX_RETRIES);

   wbm_state_e        r_state, w_state;
   logic [31:0]       r_entry, w_entry;
   logic [1:0]        r_idx, w_idx;
   logic [3:0]        r_tmo, w_tmo;
   logic [7:0]        r_retry, w_retry;
   logic [IDLE_W-1:0] r_idle, w_idle;
   logic [3:0]        r_adr, w_adr;
   logic [7:0]        r_dat, w_dat;
   logic              r_we, w_we;
   logic              r_ready, w_ready;
   logic              r_done, w_done;
   logic              r_err, w_err;
   logic              r_status, w_status;

   logic [1:0]        w_nidx;
   logic              w_tmo_hit;
   logic              w_retry_last;
   logic              w_rd_bit;

   assign w_nidx       = r_idx + 2'd1;
   assign w_tmo_hit    = (r_tmo == TMO_LAST);
   assign w_retry_last = (MAX_RETRIES != 0) && (({1'b0, r_retry} + 9'd1) == RETRY_LIMIT);
   assign w_rd_bit     = ((wb.wb_dat_i & 8'h01) != 8'h00);

   // State, counters, bus fields and output pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= GLITCH_WBM_IDLE;
         r_entry  <= '0;
         r_idx    <= '0;
         r_tmo    <= '0;
         r_retry  <= '0;
         r_idle   <= '0;
         r_adr    <= '0;
         r_dat    <= '0;
         r_we     <= 1'b0;
         r_ready  <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_status <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_entry  <= w_entry;
         r_idx    <= w_idx;
         r_tmo    <= w_tmo;
         r_retry  <= w_retry;
         r_idle   <= w_idle;
         r_adr    <= w_adr;
         r_dat    <= w_dat;
         r_we     <= w_we;
         r_ready  <= w_ready;
         r_done   <= w_done;
         r_err    <= w_err;
         r_status <= w_status;
      end
   end

   // Next-state logic; bus fields are loaded on entry to STB/PSTB so they
   // stay stable for the whole strobe/wait window.
   always_comb begin
      w_state  = r_state;
      w_entry  = r_entry;
      w_idx    = r_idx;
      w_tmo    = r_tmo;
      w_retry  = r_retry;
      w_idle   = r_idle;
      w_adr    = r_adr;
      w_dat    = r_dat;
      w_we     = r_we;
      w_status = r_status;
      w_done   = 1'b0;
      w_err    = 1'b0;

      case (r_state)
         GLITCH_WBM_IDLE: begin
            if (POLL_EN && (r_idle == POLL_LAST)) begin
               w_state = GLITCH_WBM_PSTB;
               w_idle  = '0;
               w_adr   = GLITCH_STATUS;
               w_dat   = '0;
               w_we    = 1'b0;
            end else if (cmd_valid_i && r_ready) begin
               w_state = GLITCH_WBM_STB;
               w_idle  = '0;
               w_entry = cmd_data_i;
               w_idx   = '0;
               w_retry = '0;
               w_adr   = queue_adr(2'd0);
               w_dat   = cmd_data_i[7:0];
               w_we    = 1'b1;
            end else if (POLL_EN) begin
               w_idle = r_idle + 1'b1;
            end
         end

         GLITCH_WBM_STB: begin
            w_state = GLITCH_WBM_WAIT;
            w_tmo   = '0;
         end

         GLITCH_WBM_WAIT: begin
            if (wb.wb_ack_i) begin
               if (r_idx == 2'd3) begin
                  w_done  = 1'b1;
                  w_state = GLITCH_WBM_IDLE;
               end else begin
                  w_idx   = w_nidx;
                  w_adr   = queue_adr(w_nidx);
                  w_dat   = r_entry[{w_nidx, 3'b000} +: 8];
                  w_state = GLITCH_WBM_STB;
               end
            end else if (w_tmo_hit) begin
               if (r_idx != 2'd3 || w_retry_last) begin
                  w_err   = 1'b1;
                  w_state = GLITCH_WBM_IDLE;
               end else begin
                  // Re-strobe QUEUE_3 only; address and data are still held.
                  w_retry = (r_retry == 8'hFF) ? r_retry : r_retry + 8'd1;
                  w_state = GLITCH_WBM_STB;
               end
            end else begin
               w_tmo = r_tmo + 4'd1;
            end
         end

         GLITCH_WBM_PSTB: begin
            w_state = GLITCH_WBM_PWAIT;
            w_tmo   = '0;
         end

         GLITCH_WBM_PWAIT: begin
            if (wb.wb_ack_i) begin
               w_status = w_rd_bit;
               w_state  = GLITCH_WBM_IDLE;
            end else if (w_tmo_hit) begin
               w_err   = 1'b1;
               w_state = GLITCH_WBM_IDLE;
            end else begin
               w_tmo = r_tmo + 4'd1;
            end
         end

         default: w_state = GLITCH_WBM_IDLE;
      endcase

      // Ready is registered: look ahead so it is already low on a poll-due cycle.
      w_ready = (w_state == GLITCH_WBM_IDLE) && !(POLL_EN && (w_idle == POLL_LAST));
   end

   assign cmd_ready_o    = r_ready;
   assign done_o         = r_done;
   assign err_o          = r_err;
   assign status_ready_o = r_status;
   assign busy_o         = (r_state != GLITCH_WBM_IDLE);

   assign wb.wb_adr_o = r_adr;
   assign wb.wb_dat_o = r_dat;
   assign wb.wb_we_o  = r_we;
   assign wb.wb_stb_o = (r_state == GLITCH_WBM_STB) || (r_state == GLITCH_WBM_PSTB);

endmodule

// File: tb/tb_glitch_wb_master.sv
// Bench for glitch_wb_master: table of glitch entries against a model slave
// (configurable FIFO-full count and missing-ack byte), a write scoreboard,
// plus hand sequences for polling, poll/command priority and mid-entry reset.
module tb_glitch_wb_master;
   import glitch_wb_master_pkg::*;

   localparam int AT = 4;
   localparam int MR = 4;
   localparam int PP = 16;

   typedef struct packed {
      logic [3:0] adr;
      logic [7:0] dat;
   } wr_t;

   typedef struct {
      logic [31:0] data;
      int          full;
      int          nack;
      bit          sync;
      bit          exp_done;
      int          exp_lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [31:0] cmd_data = '0;
   logic        cmd_ready, done, err, busy, status_ready;

   glitch_wb_master_if bus();

   glitch_wb_master #(
      .ACK_TIMEOUT(AT),
      .MAX_RETRIES(MR),
      .POLL_PERIOD(PP)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .cmd_valid_i    (cmd_valid),
      .cmd_data_i     (cmd_data),
      .cmd_ready_o    (cmd_ready),
      .done_o         (done),
      .err_o          (err),
      .busy_o         (busy),
      .status_ready_o (status_ready),
      .wb             (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_vec = 0;
   int   n_miss = 0;
   wr_t  exp_q[$];
   wr_t  e;
   int   full_left = 0;
   bit   nack_en = 1'b0;
   logic [3:0] nack_adr = '0;
   bit   pending = 1'b0;
   bit   prev_stb = 1'b0;
   logic [3:0] last_adr = '0;
   logic [7:0] last_dat = '0;
   logic       last_we = 1'b0;
   logic [3:0] last_wr_adr = '0;
   int   polls = 0;
   int   last_poll_cyc = -1;
   int   pushes = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string nm);
      n_vec++;
      n_miss++;
      $display("FAIL %s: no response within bound (cycle %0d)", nm, cyc);
   endtask

   // Model slave (ack one cycle after the strobe) and bus monitor.
   always @(negedge clk) begin
      if (!rst_ni) begin
         bus.wb_ack_i = 1'b0;
         pending      = 1'b0;
         prev_stb     = 1'b0;
      end else begin
         bus.wb_ack_i = pending;
         pending      = 1'b0;
         if (bus.wb_stb_o) begin
            chk("stb_one_cycle", {31'b0, prev_stb}, 32'd0);
            last_adr = bus.wb_adr_o;
            last_dat = bus.wb_dat_o;
            last_we  = bus.wb_we_o;
            if (bus.wb_we_o) begin
               last_wr_adr = bus.wb_adr_o;
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_miss++;
                  $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h, expected no write (cycle %0d)",
                           bus.wb_adr_o, bus.wb_dat_o, cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("wr_adr", {28'b0, bus.wb_adr_o}, {28'b0, e.adr});
                  chk("wr_dat", {24'b0, bus.wb_dat_o}, {24'b0, e.dat});
               end
               if (nack_en && bus.wb_adr_o == nack_adr) begin
                  pending = 1'b0;
               end else if (bus.wb_adr_o == GLITCH_QUEUE_3 && full_left > 0) begin
                  full_left--;
               end else begin
                  pending = 1'b1;
                  if (bus.wb_adr_o == GLITCH_QUEUE_3) pushes++;
               end
            end else begin
               chk("poll_adr", {28'b0, bus.wb_adr_o}, {28'b0, GLITCH_STATUS});
               polls++;
               last_poll_cyc = cyc;
               pending = 1'b1;
            end
         end else if (busy) begin
            chk("adr_hold", {28'b0, bus.wb_adr_o}, {28'b0, last_adr});
            chk("dat_hold", {24'b0, bus.wb_dat_o}, {24'b0, last_dat});
            chk("we_hold", {31'b0, bus.wb_we_o}, {31'b0, last_we});
         end
         prev_stb = bus.wb_stb_o;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, output int hs);
      hs = -1;
      cmd_data  = d;
      cmd_valid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if (cmd_ready) begin
            tick();
            hs = cyc;
            break;
         end
         tick();
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_result(output int rc, output bit d, output bit ef);
      rc = -1;
      d  = 1'b0;
      ef = 1'b0;
      for (int k = 0; k < 300; k++) begin
         tick();
         if (done || err) begin
            rc = cyc;
            d  = done;
            ef = err;
            break;
         end
      end
   endtask

   task automatic wait_poll(output int p);
      int start;
      start = polls;
      p = -1;
      for (int k = 0; k < 4 * PP; k++) begin
         tick();
         if (polls != start) begin
            p = last_poll_cyc;
            break;
         end
      end
      if (p < 0) bound_fail("poll_wait");
   endtask

   task automatic run_vec(input vec_t v);
      int hs, rc, p, q3n, push0;
      bit d, ef;
      wr_t w;
      full_left = v.full;
      nack_en   = (v.nack >= 0);
      nack_adr  = GLITCH_QUEUE_0 + 4'(v.nack);
      q3n = (v.full >= MR) ? MR : v.full + 1;
      for (int b = 0; b < 4; b++) begin
         if (v.nack >= 0 && b > v.nack) break;
         w.adr = GLITCH_QUEUE_0 + 4'(b);
         w.dat = v.data[8*b +: 8];
         if (b == 3) repeat (q3n) exp_q.push_back(w);
         else exp_q.push_back(w);
      end
      push0 = pushes;
      p = 0;
      if (v.sync) begin
         wait_poll(p);
         repeat (PP + 1) tick();
      end
      send(v.data, hs);
      if (hs < 0) begin
         bound_fail("handshake");
         exp_q.delete();
         return;
      end
      if (v.sync) begin
         chk("poll_before_cmd", last_poll_cyc, p + PP + 2);
         chk("cmd_after_poll", hs, p + PP + 5);
      end
      wait_result(rc, d, ef);
      if (rc < 0) begin
         bound_fail("result");
      end else begin
         chk("done", {31'b0, d}, {31'b0, v.exp_done});
         chk("err", {31'b0, ef}, {31'b0, !v.exp_done});
         chk("latency", rc - hs, v.exp_lat);
         chk("ready_after", {31'b0, cmd_ready}, 32'd1);
         chk("busy_after", {31'b0, busy}, 32'd0);
         tick();
         chk("pulse_width", {31'b0, done | err}, 32'd0);
      end
      chk("fifo_pushes", pushes - push0, v.exp_done ? 1 : 0);
      chk("writes_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   vec_t vt[9];

   initial begin
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int p1, p2, hs;
      bus.wb_dat_i = 8'h01;

      //            data          full nack sync done lat
      vt[0] = '{32'hDEADBEEF, 0, -1, 1'b0, 1'b1, 8};
      vt[1] = '{32'h12345678, 3, -1, 1'b0, 1'b1, 23};
      vt[2] = '{32'hA5A50F0F, 4, -1, 1'b0, 1'b0, 26};
      vt[3] = '{32'hCAFEF00D, 0,  1, 1'b0, 1'b0, 7};
      vt[4] = '{32'h00000000, 0, -1, 1'b0, 1'b1, 8};
      vt[5] = '{32'hFFFFFFFF, 1, -1, 1'b0, 1'b1, 13};
      vt[6] = '{32'h0BADF00D, 0,  0, 1'b0, 1'b0, 5};
      vt[7] = '{32'h13579BDF, 0,  2, 1'b0, 1'b0, 9};
      vt[8] = '{32'hC0FFEE11, 0, -1, 1'b1, 1'b1, 8};

      // Reset state
      tick();
      chk("rst_ready", {31'b0, cmd_ready}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_status", {31'b0, status_ready}, 32'd0);
      chk("rst_stb", {31'b0, bus.wb_stb_o}, 32'd0);
      chk("rst_adr", {28'b0, bus.wb_adr_o}, 32'd0);
      tick();
      rst_ni = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(vt[i]);

      // Poll interval and status mirroring, including bit-0 selection
      wait_poll(p1);
      wait_poll(p2);
      chk("poll_interval", p2 - p1, PP + 2);
      tick();
      tick();
      chk("status_one", {31'b0, status_ready}, 32'd1);
      bus.wb_dat_i = 8'hFE;
      wait_poll(p1);
      tick();
      tick();
      chk("status_zero", {31'b0, status_ready}, 32'd0);
      bus.wb_dat_i = 8'h01;
      wait_poll(p1);
      tick();
      tick();
      chk("status_again", {31'b0, status_ready}, 32'd1);

      // Reset while waiting for the ack of byte 2
      full_left   = 0;
      nack_en     = 1'b0;
      last_wr_adr = GLITCH_STATUS;
      for (int b = 0; b < 4; b++) begin
         e.adr = GLITCH_QUEUE_0 + 4'(b);
         e.dat = 8'(32'hA1B2C3D4 >> (8 * b));
         exp_q.push_back(e);
      end
      send(32'hA1B2C3D4, hs);
      for (int k = 0; k < 20 && last_wr_adr != GLITCH_QUEUE_2; k++) tick();
      if (last_wr_adr != GLITCH_QUEUE_2) bound_fail("reach_queue2");
      tick();
      chk("wait_busy", {31'b0, busy}, 32'd1);
      rst_ni = 1'b0;
      #1;
      chk("arst_stb", {31'b0, bus.wb_stb_o}, 32'd0);
      chk("arst_busy", {31'b0, busy}, 32'd0);
      chk("arst_adr", {28'b0, bus.wb_adr_o}, 32'd0);
      chk("arst_dat", {24'b0, bus.wb_dat_o}, 32'd0);
      chk("arst_we", {31'b0, bus.wb_we_o}, 32'd0);
      chk("arst_ready", {31'b0, cmd_ready}, 32'd0);
      chk("arst_status", {31'b0, status_ready}, 32'd0);
      chk("writes_before_reset", exp_q.size(), 1);
      exp_q.delete();
      tick();
      tick();
      rst_ni = 1'b1;
      run_vec('{32'h01020304, 0, -1, 1'b0, 1'b1, 8});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
